alu_logic_pipe: RTL and testbench
=================================

Name: alu_logic_pipe

Overview:
Parametrised, pipelined successor to the 3-bit registered XNOR ALU. Takes two WIDTH-bit operands and a 3-bit opcode covering bitwise logic, add, subtract, multiply and multiply-accumulate. Produces a 2*WIDTH-bit registered result behind a valid/ready handshake. Sits between the operand register file and the result writeback path, and absorbs writeback stalls.

Parameters:
WIDTH, 3, operand width in bits (>=2); result width is 2*WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  global enable; 0 freezes the whole pipeline
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept this cycle
op  input  3  opcode (below)
acc_clr  input  1  clear accumulator and ovf (sampled with accepted op only)
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
out_valid  output  1  Dout holds a result
out_ready  input  1  downstream consumes Dout
Dout  output  2*WIDTH  result
ovf  output  1  sticky MAC overflow flag

Behaviour:
- Reset (rst_n=0 at posedge): s1_valid=0, out_valid=0, Dout=0, accumulator=0, ovf=0. in_ready is 0 while rst_n=0. Reset overrides every other input, including mid-transfer; in-flight operations are discarded.
- Stage 1 (S1): registers A, B, op and acc_clr on accept. Accept = in_valid & in_ready.
- Stage 2 (output register): computes from S1 and loads Dout/out_valid.
- advance = en & (!out_valid | out_ready).
- in_ready = en & (!s1_valid | advance). This is combinational; no skid buffer.
- Latency: accept at edge N gives out_valid=1 with result after edge N+1. Throughput is 1 op/cycle with out_ready held high.
- On advance: out_valid <= s1_valid. If s1_valid, Dout <= result. If !s1_valid, Dout holds its last value.
- out_valid with out_ready=0: Dout, out_valid and ovf are held stable. S1 may still fill once, then in_ready=0.
- en=0: no state changes (except reset), in_ready=0, outputs held.
- Opcodes (bitwise results zero-extended to 2*WIDTH):
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 XNOR (the WIDTH bits are inverted; upper bits are 0)
  - 100 ADD: A+B, WIDTH+1 bits, zero-extended
  - 101 SUB: A-B, two's complement sign-extended to 2*WIDTH
  - 110 MUL: A*B unsigned, full 2*WIDTH
  - 111 MAC: acc <= acc + A*B modulo 2^(2*WIDTH); Dout <= new acc
- Accumulator:
  - Updates only when a MAC op moves S1 to stage 2.
  - ovf is set on carry out of bit 2*WIDTH-1 and stays set until cleared.
- acc_clr:
  - Takes effect when its op moves S1 to stage 2, for any opcode.
  - Sets acc=0 and ovf=0 first. If that op is MAC, acc then loads A*B (clear-then-accumulate) and ovf=0.
  - Non-MAC ops with acc_clr still produce their normal Dout.
- Non-MAC ops never alter acc or ovf.
- acc_clr on a non-accepted cycle is ignored.

Test Plan:
- WIDTH=3, out_ready=1: op=011, A=3'b011, B=3'b110 accepted at edge 1 -> after edge 2: out_valid=1, Dout=6'b000010. Back-to-back op=000 then 001 with A=5, B=3 -> Dout=6'b000001 then 6'b000111 on consecutive cycles.
- Arithmetic: ADD A=7, B=7 -> 6'b001110. SUB A=1, B=3 -> 6'b111110. MUL A=7, B=7 -> 6'b110001.
- MAC:
  - Step 1: MAC A=7, B=7 with acc_clr=1 -> Dout=49, ovf=0.
  - Step 2: MAC A=7, B=7 -> Dout=34 (98 mod 64), ovf=1.
  - Step 3: AND op -> ovf stays 1.
  - Step 4: MAC A=1, B=1 with acc_clr=1 -> Dout=1, ovf=0.
- Backpressure: hold out_ready=0 with in_valid=1 every cycle -> exactly two ops accepted, then in_ready=0 and Dout stable. Raise out_ready -> results emerge in order, none lost or duplicated.
- en=0 for 3 cycles with out_valid=1 and S1 full -> all outputs frozen, in_ready=0. Resume -> order preserved.
- Reset mid-operation: accept MAC, then assert rst_n=0 one cycle later -> next edge gives out_valid=0, Dout=0, acc=0, ovf=0. The first accepted MAC after reset with A=2, B=3 -> Dout=6.

Source files
------------

// File: rtl/alu_logic_pipe.sv
// Two-stage pipelined ALU: S1 operand register, then a result register behind
// a valid/ready handshake, with a wrapping MAC accumulator and sticky overflow.
module alu_logic_pipe #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic                 acc_clr,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Dout,
  output logic                 ovf
);
  localparam int RW = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR  = 3'b001, OP_XOR = 3'b010, OP_XNOR = 3'b011,
    OP_ADD = 3'b100, OP_SUB = 3'b101, OP_MUL = 3'b110, OP_MAC  = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             clr;
  } s1_t;

  s1_t            s1_q, s1_d;
  logic           s1_vld_q, s1_vld_d;
  logic           out_vld_q, out_vld_d;
  logic [RW-1:0]  dout_q, dout_d;
  logic [RW-1:0]  acc_q, acc_d;
  logic           ovf_q, ovf_d;

  logic           advance, accept;
  logic [RW-1:0]  a_x, b_x, prod, acc_base, result;
  logic [RW:0]    mac_sum;
  logic           ovf_base;

  assign advance  = en & (~out_vld_q | out_ready);
  assign in_ready = rst_n & en & (~s1_vld_q | advance);
  assign accept   = in_valid & in_ready;

  assign a_x  = {{WIDTH{1'b0}}, s1_q.a};
  assign b_x  = {{WIDTH{1'b0}}, s1_q.b};
  assign prod = a_x * b_x;

  // acc_clr zeroes the accumulator before this op's MAC contribution is added
  assign acc_base = s1_q.clr ? '0 : acc_q;
  assign ovf_base = s1_q.clr ? 1'b0 : ovf_q;
  assign mac_sum  = {1'b0, acc_base} + {1'b0, prod};

  always_comb begin
    result = '0;
    case (s1_q.op)
      OP_AND:  result = {{WIDTH{1'b0}}, s1_q.a & s1_q.b};
      OP_OR:   result = {{WIDTH{1'b0}}, s1_q.a | s1_q.b};
      OP_XOR:  result = {{WIDTH{1'b0}}, s1_q.a ^ s1_q.b};
      OP_XNOR: result = {{WIDTH{1'b0}}, ~(s1_q.a ^ s1_q.b)};
      OP_ADD:  result = a_x + b_x;
      OP_SUB:  result = a_x - b_x;
      OP_MUL:  result = prod;
      OP_MAC:  result = mac_sum[RW-1:0];
      default: result = '0;
    endcase
  end

  always_comb begin
    s1_d      = s1_q;
    s1_vld_d  = s1_vld_q;
    out_vld_d = out_vld_q;
    dout_d    = dout_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;

    if (advance) begin
      out_vld_d = s1_vld_q;
      s1_vld_d  = 1'b0;
      if (s1_vld_q) begin
        dout_d = result;
        acc_d  = acc_base;
        ovf_d  = ovf_base;
        if (s1_q.op == OP_MAC) begin
          acc_d = mac_sum[RW-1:0];
          ovf_d = ovf_base | mac_sum[RW];
        end
      end
    end

    if (accept) begin
      s1_vld_d = 1'b1;
      s1_d.a   = A;
      s1_d.b   = B;
      s1_d.op  = op_e'(op);
      s1_d.clr = acc_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      dout_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
      dout_q    <= dout_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = out_vld_q;
  assign Dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Bench for alu_logic_pipe: transaction-level model (results computed at accept
// in program order) checked every cycle, plus directed literal expectations.
module tb_alu_logic_pipe;
  localparam int W = 3;
  localparam int M = 1 << (2 * W);
  localparam int WM = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n, en, in_valid, in_ready, acc_clr, out_valid, out_ready, ovf;
  logic [2:0]     op;
  logic [W-1:0]   A, B;
  logic [2*W-1:0] Dout;

  always #5 clk = ~clk;

  alu_logic_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_clr(acc_clr), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .Dout(Dout), .ovf(ovf)
  );

  int errs = 0, checks = 0, n_acc = 0;
  bit chk_on = 1'b0;

  // model: one pending op (S1) and the visible output; results fixed at accept
  int m_s1 = 0, m_s1_res = 0, m_s1_ovf = 0;
  int m_ov = 0, m_dout = 0, m_ovf = 0;
  int m_acc = 0, m_aovf = 0;

  task automatic model_op(input int o, input int c, input int a, input int b, output int res);
    int s;
    if (c != 0) begin m_acc = 0; m_aovf = 0; end
    case (o)
      0: res = a & b;
      1: res = a | b;
      2: res = a ^ b;
      3: res = (~(a ^ b)) & WM;
      4: res = a + b;
      5: res = (a - b + M) % M;
      6: res = a * b;
      default: begin
        s = m_acc + a * b;
        if (s >= M) m_aovf = 1;
        m_acc = s % M;
        res = m_acc;
      end
    endcase
  endtask

  task automatic step(input bit r, input bit e, input bit v, input int o, input bit c,
                      input int a, input int b, input bit ordy);
    bit adv, take;
    int res;
    rst_n = r; en = e; in_valid = v; op = 3'(o); acc_clr = c;
    A = W'(a); B = W'(b); out_ready = ordy;
    #1;
    if (in_valid && in_ready) n_acc++;
    @(posedge clk);
    if (!r) begin
      m_s1 = 0; m_ov = 0; m_dout = 0; m_ovf = 0; m_acc = 0; m_aovf = 0;
    end else if (e) begin
      adv  = (m_ov == 0) || ordy;
      take = v && ((m_s1 == 0) || adv);
      if (adv) begin
        m_ov = m_s1;
        if (m_s1 != 0) begin m_dout = m_s1_res; m_ovf = m_s1_ovf; end
        m_s1 = 0;
      end
      if (take) begin
        model_op(o, int'(c), a & WM, b & WM, res);
        m_s1 = 1; m_s1_res = res; m_s1_ovf = m_aovf;
      end
    end
    #2;
  endtask

  task automatic issue(input int o, input bit c, input int a, input int b);
    step(1, 1, 1, o, c, a, b, 1);
  endtask

  task automatic idle(input bit ordy);
    step(1, 1, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic expect_out(input string nm, input bit v, input int d, input bit f);
    checks++;
    if (out_valid !== v || Dout !== (2*W)'(d) || ovf !== f) begin
      errs++;
      $display("FAIL %s: dut v=%b Dout=%0d ovf=%b, want v=%b Dout=%0d ovf=%b",
               nm, out_valid, Dout, ovf, v, d, f);
    end
    checks++;
    if (m_ov != int'(v) || m_dout != d || m_ovf != int'(f)) begin
      errs++;
      $display("FAIL %s(model): v=%0d Dout=%0d ovf=%0d, want v=%b Dout=%0d ovf=%b",
               nm, m_ov, m_dout, m_ovf, v, d, f);
    end
  endtask

  always @(negedge clk) begin
    bit exp_ir;
    if (chk_on) begin
      exp_ir = rst_n && en && ((m_s1 == 0) || (m_ov == 0) || out_ready);
      checks++;
      if (in_ready !== exp_ir || out_valid !== (m_ov != 0) ||
          Dout !== (2*W)'(m_dout) || ovf !== (m_ovf != 0)) begin
        errs++;
        $display("FAIL cycle @%0t: dut rdy=%b v=%b Dout=%0d ovf=%b, want rdy=%b v=%0d Dout=%0d ovf=%0d",
                 $time, in_ready, out_valid, Dout, ovf, exp_ir, m_ov, m_dout, m_ovf);
      end
    end
  end

  initial begin
    step(0, 1, 1, 7, 0, 5, 5, 1);
    chk_on = 1'b1;
    step(0, 1, 1, 7, 0, 5, 5, 1);
    expect_out("reset", 0, 0, 0);

    issue(3, 0, 3, 6); idle(1);
    expect_out("xnor", 1, 2, 0);
    issue(0, 0, 5, 3); issue(1, 0, 5, 3);
    expect_out("and", 1, 1, 0);
    idle(1);
    expect_out("or", 1, 7, 0);

    issue(4, 0, 7, 7); idle(1); expect_out("add", 1, 14, 0);
    issue(5, 0, 1, 3); idle(1); expect_out("sub", 1, 62, 0);
    issue(6, 0, 7, 7); idle(1); expect_out("mul", 1, 49, 0);

    issue(7, 1, 7, 7); idle(1); expect_out("mac1", 1, 49, 0);
    issue(7, 0, 7, 7); idle(1); expect_out("mac2", 1, 34, 1);
    issue(0, 0, 7, 1); idle(1); expect_out("and_keeps_ovf", 1, 1, 1);
    issue(7, 1, 1, 1); idle(1); expect_out("mac_clr", 1, 1, 0);

    // backpressure: only S1 and the output register can fill
    idle(1);
    n_acc = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 4, 0, i + 1, 1, 0);
    checks++;
    if (n_acc != 2) begin
      errs++;
      $display("FAIL bp_accepts: got %0d, want 2", n_acc);
    end
    expect_out("bp_hold", 1, 2, 0);
    idle(1); expect_out("bp_drain1", 1, 3, 0);
    idle(1); expect_out("bp_drain2", 0, 3, 0);

    // freeze with both stages full
    step(1, 1, 1, 6, 0, 2, 3, 0);
    step(1, 1, 1, 4, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0, 7, 7, 1);
      expect_out("en_freeze", 1, 6, 0);
    end
    idle(1); expect_out("en_resume", 1, 2, 0);
    idle(1);

    // reset discards an in-flight MAC and the accumulator
    issue(7, 1, 3, 3);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    expect_out("mid_reset", 0, 0, 0);
    issue(7, 0, 2, 3); idle(1);
    expect_out("mac_after_reset", 1, 6, 0);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(99) < 85), ($urandom_range(99) < 70),
           int'($urandom_range(7)), ($urandom_range(7) == 0),
           int'($urandom_range(WM)), int'($urandom_range(WM)), ($urandom_range(99) < 70));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
